// File: rtl/regfile_2r1w_clr.sv
// General-purpose register store: one byte-enabled write port, two registered
// read ports with write-first bypass, and a sequential bulk-clear engine.
module regfile_2r1w_clr #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic                  rd_en_a,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic                  rd_valid_a,
    input  logic                  rd_en_b,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    output logic [DATA_W-1:0]     rd_data_b,
    output logic                  rd_valid_b,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  wr_err
);

    localparam int               NB      = DATA_W / 8;
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   cnt, cnt_next;
    logic                clr_en;
    logic                wr_ok;
    logic [DATA_W-1:0]   mem      [DEPTH];
    logic [DATA_W-1:0]   mem_next [DEPTH];

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign busy  = (state == CLEAR);
    assign wr_ok = wr_en && !busy && addr_ok(wr_addr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        clr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    cnt_next   = '0;
                end
            end
            CLEAR: begin
                clr_en = 1'b1;
                if (cnt == LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // mem_next is the array as it will be after this edge; reads sample it to
    // get write-first and clear-first behaviour without separate bypass muxes.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_next[i] = mem[i];
            if (wr_ok && (wr_addr == ADDR_W'(i))) begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_be[b]) mem_next[i][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
            if (clr_en && (cnt == ADDR_W'(i))) mem_next[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_err <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= mem_next[i];
            wr_err <= wr_en && !wr_ok;
        end
    end

    // Read handshake: rd_en_x sampled at an edge yields rd_valid_x for exactly
    // the following cycle; without a request, valid drops and data holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_a  <= '0;
            rd_valid_a <= 1'b0;
            rd_data_b  <= '0;
            rd_valid_b <= 1'b0;
        end else begin
            rd_valid_a <= rd_en_a;
            rd_valid_b <= rd_en_b;
            if (rd_en_a) rd_data_a <= addr_ok(rd_addr_a) ? mem_next[rd_addr_a] : '0;
            if (rd_en_b) rd_data_b <= addr_ok(rd_addr_b) ? mem_next[rd_addr_b] : '0;
        end
    end

endmodule
